// File: rtl/i2s_adc_rx.sv
// Purpose: WM8731 ADC-side I2S receiver; oversamples BCLK/LRCK/DAT, deserialises stereo frames into a show-ahead FIFO.
// Latency: 4 clk from raw BCLK rising edge to frame commit, src_valid 5 clk after that edge when the FIFO was empty.
// Backpressure: src_ready low holds the head frame; a commit into a full FIFO with no same-cycle read drops the frame and sets overflow.
//
// Ports:
//   clk, reset            system clock (>= 4x adc_bclk), async active-high reset
//   enable                capture enable; low aborts the current frame and waits for a fresh left start
//   adc_bclk/lrck/dat     codec-driven I2S inputs, asynchronous to clk
//   src_data/valid/ready  Avalon-ST source, {left, right} with left in the upper half
//   overflow              sticky drop flag, cleared by clear_overflow (set wins on collision)
//   fifo_level            FIFO occupancy, present only when I2S_ADC_RX_LEVEL_EN is defined

// Purpose: generic show-ahead FIFO with wrap-bit pointers.
// Latency: write visible at the read port the cycle after the push.
// Backpressure: o_wr_rdy drops when full unless a read happens in the same cycle.
module i2s_adc_rx_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_vld,
  input  logic [WIDTH-1:0]  i_wr_dat,
  output logic              o_wr_rdy,
  output logic              o_rd_vld,
  output logic [WIDTH-1:0]  o_rd_dat,
  input  logic              i_rd_rdy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_pop    = ~w_empty & i_rd_rdy;
  // A read in the same cycle frees the slot being written, so full+read still accepts.
  assign o_wr_rdy = ~w_full | w_pop;
  assign w_push   = i_wr_vld & o_wr_rdy;
  assign o_rd_vld = ~w_empty;
  assign o_rd_dat = r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_dat;
        r_wr_ptr                    <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

module i2s_adc_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    adc_bclk,
  input  logic                    adc_lrck,
  input  logic                    adc_dat,
  output logic [2*DATA_WIDTH-1:0] src_data,
  output logic                    src_valid,
  input  logic                    src_ready,
  output logic                    overflow,
  input  logic                    clear_overflow
`ifdef I2S_ADC_RX_LEVEL_EN
  ,
  output logic [ADDR_W:0]         fifo_level
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_WAIT_SYNC = 2'd0,
    S_LEFT      = 2'd1,
    S_RIGHT     = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronisers and BCLK rising-edge detect
  // ---------------------------------------------------------------
  logic r_bclk_s1, r_bclk_s2, r_bclk_d;
  logic r_lrck_s1, r_lrck_s2;
  logic r_dat_s1,  r_dat_s2;
  logic w_bclk_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_dat_s1  <= 1'b0;
      r_dat_s2  <= 1'b0;
    end else begin
      r_bclk_s1 <= adc_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lrck_s1 <= adc_lrck;
      r_lrck_s2 <= r_lrck_s1;
      r_dat_s1  <= adc_dat;
      r_dat_s2  <= r_dat_s1;
    end
  end

  assign w_bclk_rise = r_bclk_s2 & ~r_bclk_d;

  // LRCK and DAT change on the BCLK falling edge, so both are settled in the
  // synchronisers by the time the rising edge is seen and can be captured together.
  logic r_smp_vld;
  logic r_smp_lrck;
  logic r_smp_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp_vld  <= 1'b0;
      r_smp_lrck <= 1'b0;
      r_smp_dat  <= 1'b0;
    end else begin
      r_smp_vld <= w_bclk_rise;
      if (w_bclk_rise) begin
        r_smp_lrck <= r_lrck_s2;
        r_smp_dat  <= r_dat_s2;
      end
    end
  end

  // ---------------------------------------------------------------
  // Deserialiser FSM
  // ---------------------------------------------------------------
  state_t                  r_state;
  logic                    r_prev_lrck;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   r_left;
  logic [DATA_WIDTH-1:0]   w_shift_nxt;
  logic                    w_trans;
  logic                    r_push;
  logic [2*DATA_WIDTH-1:0] r_frame;

  assign w_trans = r_smp_lrck ^ r_prev_lrck;

  // Bits are placed MSB-first at their final position, so a word cut short by
  // an early LRCK transition is already MSB-aligned with zero LSBs. Once the
  // counter reaches DATA_WIDTH no position matches and extra bits fall away.
  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r_cnt == CNT_W'(DATA_WIDTH - 1 - i)) begin
        w_shift_nxt[i] = r_smp_dat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_WAIT_SYNC;
      r_prev_lrck <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_left      <= '0;
      r_push      <= 1'b0;
      r_frame     <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_smp_vld) begin
        r_prev_lrck <= r_smp_lrck;
      end

      if (!enable) begin
        r_state <= S_WAIT_SYNC;
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (r_smp_vld) begin
        case (r_state)
          S_WAIT_SYNC: begin
            // Only a 1->0 edge starts a frame; everything else is discarded.
            if (w_trans && !r_smp_lrck) begin
              r_cnt   <= '0;
              r_shift <= '0;
              r_state <= S_LEFT;
            end
          end
          S_LEFT: begin
            if (w_trans && r_smp_lrck) begin
              r_left  <= r_shift;
              r_cnt   <= '0;
              r_shift <= '0;
              r_state <= S_RIGHT;
            end else if (r_cnt < CNT_MAX) begin
              r_shift <= w_shift_nxt;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          S_RIGHT: begin
            if (w_trans && !r_smp_lrck) begin
              r_frame <= {r_left, r_shift};
              r_push  <= 1'b1;
              r_cnt   <= '0;
              r_shift <= '0;
              r_state <= S_LEFT;
            end else if (r_cnt < CNT_MAX) begin
              r_shift <= w_shift_nxt;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_WAIT_SYNC;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // Frame FIFO and overflow flag
  // ---------------------------------------------------------------
  logic w_wr_rdy;

  i2s_adc_rx_fifo #(
    .WIDTH  (2*DATA_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr_vld (r_push),
    .i_wr_dat (r_frame),
    .o_wr_rdy (w_wr_rdy),
    .o_rd_vld (src_valid),
    .o_rd_dat (src_data),
    .i_rd_rdy (src_ready)
  );

  logic r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (r_push && !w_wr_rdy) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

`ifdef I2S_ADC_RX_LEVEL_EN
  // Occupancy tracked separately from the pointers so it only exists when exported.
  logic            w_lvl_push;
  logic            w_lvl_pop;
  logic [ADDR_W:0] r_level;

  assign w_lvl_push = r_push & w_wr_rdy;
  assign w_lvl_pop  = src_valid & src_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_lvl_push, w_lvl_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign fifo_level = r_level;
`else
  // Occupancy is not exported; full/empty come from the FIFO pointers alone.
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Purpose: directed bench for i2s_adc_rx with a bench-driven codec (BCLK = clk/8).
// Latency: checks the 5-clk BCLK-edge-to-src_valid path and FIFO ordering.
// Backpressure: exercises src_ready hold, overflow drop, and simultaneous push/pop.
module tb_i2s_adc_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          adc_bclk;
  logic          adc_lrck;
  logic          adc_dat;
  logic [2*DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          overflow;
  logic          clear_overflow;
`ifdef I2S_ADC_RX_LEVEL_EN
  logic [2:0]    fifo_level;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic cur_lr;

  always #5 clk = ~clk;

  i2s_adc_rx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4),
    .ADDR_W     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .adc_bclk       (adc_bclk),
    .adc_lrck       (adc_lrck),
    .adc_dat        (adc_dat),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef I2S_ADC_RX_LEVEL_EN
    ,
    .fifo_level     (fifo_level)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One BCLK period: falling edge with new LRCK/DAT, rising edge 4 clk later.
  task automatic slot(input logic lr, input logic d);
    adc_bclk = 1'b0;
    adc_lrck = lr;
    adc_dat  = d;
    tick(4);
    adc_bclk = 1'b1;
    tick(4);
  endtask

  task automatic send_bits(input logic lr, input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      slot(lr, w[i]);
    end
  endtask

  // The transition slot carries a 1 that the receiver must ignore.
  task automatic send_word(input logic lr, input logic [31:0] w, input int n, input int pad);
    if (cur_lr !== lr) begin
      slot(lr, 1'b1);
      cur_lr = lr;
    end
    send_bits(lr, w, n - 1, 0);
    for (int i = 0; i < pad; i++) begin
      slot(lr, 1'b1);
    end
  endtask

  task automatic close_frame();
    if (cur_lr) begin
      slot(1'b0, 1'b1);
      cur_lr = 1'b0;
    end
  endtask

  // Returns 1 ns after the clock edge on which the frame is committed.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int pad);
    send_word(1'b0, l, n, pad);
    send_word(1'b1, r, n, pad);
    close_frame();
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check({tag, "_vld"}, 64'(src_valid), 64'd1);
    check(tag, 64'(src_data), 64'(exp));
    src_ready = 1'b1;
    tick(1);
    src_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] e;

    reset          = 1'b1;
    enable         = 1'b1;
    adc_bclk       = 1'b0;
    adc_lrck       = 1'b1;
    adc_dat        = 1'b0;
    src_ready      = 1'b0;
    clear_overflow = 1'b0;
    cur_lr         = 1'b1;

    // Reset state
    tick(3);
    check("rst_valid", 64'(src_valid), 64'd0);
    check("rst_data",  64'(src_data),  64'd0);
    check("rst_ovf",   64'(overflow),  64'd0);
`ifdef I2S_ADC_RX_LEVEL_EN
    check("rst_level", 64'(fifo_level), 64'd0);
`endif
    reset = 1'b0;
    tick(2);
    slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);

    // Basic frame with latency measured from the closing BCLK rising edge
    src_ready = 1'b1;
    send_word(1'b0, 32'h1234, 16, 1);
    send_word(1'b1, 32'hABCD, 16, 1);
    adc_bclk = 1'b0;
    adc_lrck = 1'b0;
    adc_dat  = 1'b1;
    tick(4);
    adc_bclk = 1'b1;
    cur_lr   = 1'b0;
    tick(4);
    check("basic_vld_at4", 64'(src_valid), 64'd0);
    tick(1);
    check("basic_vld_at5", 64'(src_valid), 64'd1);
    check("basic_data",    64'(src_data),  64'h1234ABCD);
    tick(1);
    check("basic_one_xfer", 64'(src_valid), 64'd0);
    src_ready = 1'b0;
    tick(2);

    // Sync: stream starts mid-right, partial word must not emerge
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    send_word(1'b1, 32'h5555, 8, 0);
    send_frame(32'h0001, 32'h8000, 16, 0);
    tick(2);
    pop_check("sync_first", 32'h00018000);
    check("sync_empty", 64'(src_valid), 64'd0);

    // Short and long words
    send_frame(32'hABC, 32'hABC, 12, 0);
    tick(2);
    pop_check("short12", 32'hABC0ABC0);
    send_frame(32'hFEDCB, 32'hFEDCB, 20, 0);
    tick(2);
    pop_check("long20", 32'hFEDCFEDC);
    check("words_empty", 64'(src_valid), 64'd0);

    // Overflow with depth 4
    for (int i = 1; i <= 4; i++) begin
      send_frame(32'(16'h1000 + i), 32'(16'h2000 + i), 16, 0);
    end
    tick(2);
    check("ovf_before", 64'(overflow), 64'd0);
    send_frame(32'h1005, 32'h2005, 16, 0);
    tick(2);
    check("ovf_set",   64'(overflow), 64'd1);
    check("ovf_head_hold", 64'(src_data), 64'h10012001);
    for (int i = 1; i <= 4; i++) begin
      e = {16'(16'h1000 + i), 16'(16'h2000 + i)};
      pop_check("ovf_pop", e);
    end
    check("ovf_drained", 64'(src_valid), 64'd0);
    check("ovf_sticky",  64'(overflow),  64'd1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("ovf_clear", 64'(overflow), 64'd0);

    // Reset during bit 7 of the left word
    send_frame(32'h1111, 32'h2222, 16, 0);
    send_bits(1'b0, 32'h7777, 15, 9);
    tick(1);
    check("rstmid_queued", 64'(src_valid), 64'd1);
    reset = 1'b1;
    tick(1);
    check("rstmid_vld",  64'(src_valid), 64'd0);
    check("rstmid_data", 64'(src_data),  64'd0);
    reset = 1'b0;
    tick(1);
    send_bits(1'b0, 32'h7777, 8, 0);
    send_word(1'b1, 32'h3333, 16, 0);
    send_frame(32'h4444, 32'h5555, 16, 0);
    tick(2);
    pop_check("rstmid_next", 32'h44445555);
    check("rstmid_empty", 64'(src_valid), 64'd0);

    // Enable drop mid-right with two frames queued
    send_frame(32'hB0B1, 32'hB2B3, 16, 0);
    send_frame(32'hC0C1, 32'hC2C3, 16, 0);
    send_word(1'b0, 32'hD0D1, 16, 0);
    send_word(1'b1, 32'hD2, 8, 0);
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    send_bits(1'b1, 32'hD3, 7, 0);
    send_frame(32'hE0E1, 32'hE2E3, 16, 0);
    tick(2);
    pop_check("en_b", 32'hB0B1B2B3);
    pop_check("en_c", 32'hC0C1C2C3);
    pop_check("en_e", 32'hE0E1E2E3);
    check("en_empty", 64'(src_valid), 64'd0);
    check("en_no_ovf", 64'(overflow), 64'd0);

    // Simultaneous push and pop, including at full
    for (int i = 1; i <= 3; i++) begin
      send_frame(32'(16'hF000 + i), 32'(16'h0F00 + i), 16, 0);
    end
    tick(2);
`ifdef I2S_ADC_RX_LEVEL_EN
    check("lvl_three", 64'(fifo_level), 64'd3);
`endif
    send_frame(32'hF004, 32'h0F04, 16, 0);
    src_ready = 1'b1;
    tick(1);
    src_ready = 1'b0;
    tick(1);
`ifdef I2S_ADC_RX_LEVEL_EN
    check("lvl_pushpop", 64'(fifo_level), 64'd3);
`endif
    check("pp_head", 64'(src_data), 64'hF0020F02);
    send_frame(32'hF005, 32'h0F05, 16, 0);
    tick(2);
`ifdef I2S_ADC_RX_LEVEL_EN
    check("lvl_full", 64'(fifo_level), 64'd4);
`endif
    send_frame(32'hF006, 32'h0F06, 16, 0);
    src_ready = 1'b1;
    tick(1);
    src_ready = 1'b0;
    tick(1);
    check("pp_full_no_ovf", 64'(overflow), 64'd0);
`ifdef I2S_ADC_RX_LEVEL_EN
    check("lvl_full_pp", 64'(fifo_level), 64'd4);
`endif
    for (int i = 3; i <= 6; i++) begin
      e = {16'(16'hF000 + i), 16'(16'h0F00 + i)};
      pop_check("pp_pop", e);
    end
    check("pp_empty", 64'(src_valid), 64'd0);
`ifdef I2S_ADC_RX_LEVEL_EN
    check("lvl_zero", 64'(fifo_level), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- Receive side of the WM8731 codec digital audio interface; counterpart of the DAC transmit path (DACDAT/BCLK/DACLRCK).
- Codec is bus master: it drives ADC bit clock, ADC LR clock and serial ADC data in I2S format.
- Block oversamples these three signals on the system clock, deserialises stereo frames and buffers them in a FIFO.
- Frames are presented on an Avalon-ST source consumed by the HPS/DMA capture path.

Parameters:
- DATA_WIDTH, 16, bits per channel word; legal range 8..32.
- FIFO_DEPTH, 8, stereo frames buffered; power of two, at least 2.
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, 50 MHz; must be at least 4x adc_bclk.
- reset  in  1  asynchronous, active-high.
- enable  in  1  capture enable; low forces WAIT_SYNC.
- adc_bclk  in  1  codec bit clock, asynchronous to clk.
- adc_lrck  in  1  codec ADC LR clock: 0 = left, 1 = right.
- adc_dat  in  1  codec serial ADC data, MSB first.
- src_data  out  2*DATA_WIDTH  {left, right}; left word in the upper half.
- src_valid  out  1  head frame available.
- src_ready  in  1  sink accepts; a transfer occurs on a cycle where src_valid and src_ready are both high.
- overflow  out  1  sticky flag: a frame was dropped.
- clear_overflow  in  1  single-cycle clear of overflow.

Behaviour:
- Reset values: src_data=0, src_valid=0, overflow=0; FIFO empty; state WAIT_SYNC; shift register and bit counter 0.
- Input synchronisation:
  - adc_bclk, adc_lrck and adc_dat each pass through a 2-FF synchroniser.
  - A BCLK rising edge is detected one registered stage later (a third register).
  - At each detected rising edge, the block samples the synchronised lrck and dat together.
- I2S framing:
  - A change in sampled lrck versus the previously sampled lrck is a transition edge.
  - The dat bit sampled on the transition edge is the LSB slot of the previous word and is ignored.
  - The next DATA_WIDTH edges carry MSB..LSB.
  - Any further bits before the next transition are ignored.
  - If a transition arrives before DATA_WIDTH bits are taken, the word is MSB-aligned and the remaining LSBs are zero.
- States:
  - WAIT_SYNC: discard all data. On a 1->0 lrck transition with enable=1, clear the bit counter and go to LEFT.
  - LEFT: shift bits into the left word. On a 0->1 transition, latch the left word, clear the counter and go to RIGHT.
  - RIGHT: shift bits into the right word. On a 1->0 transition, commit {left,right} to the FIFO and go to LEFT.
  - enable=0 in any state: go to WAIT_SYNC immediately. A partial frame is discarded. FIFO contents and the output side are unaffected.
- Latency:
  - With the raw adc_bclk rising edge aligned to a clk edge, the frame commit happens on clk cycle +4.
  - With the FIFO previously empty, src_valid rises on cycle +5; src_data is valid in the same cycle.
- FIFO:
  - Show-ahead: src_data is the head entry whenever src_valid=1; it holds stable while src_ready=0.
  - Read and write in the same cycle are both honoured, including when the FIFO is full (count unchanged).
- Overflow:
  - A commit while the FIFO is full and no read occurs in that cycle drops the new frame; stored frames are untouched and overflow is set.
  - clear_overflow clears the flag. If a set and a clear land in the same cycle, the set wins.
- Reset mid-frame: all state returns to reset values asynchronously; the next capture requires a fresh left-start transition.

Optional Feature:
- Macro: I2S_ADC_RX_LEVEL_EN.
- Defined: adds output port fifo_level [ADDR_W:0], the current FIFO occupancy (0..FIFO_DEPTH).
  - Updates the cycle after each push or pop; a simultaneous push and pop leaves it unchanged.
  - Reset value 0.
- Not defined: the port is absent and no level counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Basic frame: DATA_WIDTH=16, BCLK=clk/8, enable=1, src_ready=1. Send left=0x1234, right=0xABCD in I2S format -> one transfer with src_data=0x1234ABCD, src_valid high 5 clk after the closing 1->0 lrck edge.
- Sync: stream begins mid-right-channel with value 0x5555, followed by the frame 0x0001/0x8000 -> the first output is 0x00018000; no partial frame is emitted.
- Short/long words:
  - 12 bits 0xABC per channel -> src_data=0xABC0ABC0.
  - 20-bit words 0xFEDCB -> src_data=0xFEDCFEDC.
- Overflow: FIFO_DEPTH=4, src_ready=0, send frames 1..5 -> overflow=1 after frame 5. Release ready -> frames 1..4 read out in order, then src_valid=0. Pulse clear_overflow -> overflow=0.
- Reset/enable mid-operation:
  - Assert reset during bit 7 of the left word -> src_valid=0 and FIFO empty; the next full frame is received correctly.
  - Deassert enable mid-right-word with 2 frames queued -> both queued frames are still delivered; the interrupted frame never appears.
- Level (macro defined): push 3 frames with ready=0 -> fifo_level=3. Pop 1 while a 4th frame commits in the same cycle -> fifo_level=3.
